// File: rtl/codon_counter_array_if.sv
// Bus bundle for codon_counter_array: base stream, table config, readout and status.
// Optional stop_hit is present only when CODON_STOP_EN is defined.
interface codon_counter_array_if #(
    parameter int IDX_W = 3,
    parameter int CNT_W = 4,
    parameter int LEN_W = 8
);
    logic             start;
    logic             mode;
    logic [LEN_W-1:0] gene_len;
    // A base transfers on a rising clock edge where base_valid && base_ready;
    // base must be stable while base_valid is high and base_ready is low.
    logic             base_valid;
    logic [1:0]       base;
    logic             base_ready;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [5:0]       cfg_codon;
    logic [IDX_W-1:0] sel;
    logic [CNT_W-1:0] sel_count;
    logic [CNT_W-1:0] total_codons;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;
`ifdef CODON_STOP_EN
    logic             stop_hit;
`endif

    modport master (
`ifdef CODON_STOP_EN
        input  stop_hit,
`endif
        output start, mode, gene_len, base_valid, base, cfg_we, cfg_idx, cfg_codon, sel,
        input  base_ready, sel_count, total_codons, busy, done, state_dbg
    );

    modport slave (
`ifdef CODON_STOP_EN
        output stop_hit,
`endif
        input  start, mode, gene_len, base_valid, base, cfg_we, cfg_idx, cfg_codon, sel,
        output base_ready, sel_count, total_codons, busy, done, state_dbg
    );
endinterface

// File: rtl/codon_counter_array.sv
// Nucleotide stream codon matcher with a loadable table of NUM_CODONS targets.
// Define CODON_STOP_EN to end a scan early on TAA/TAG/TGA and expose stop_hit.
module codon_counter_array #(
    parameter int NUM_CODONS = 6,
    parameter int IDX_W      = 3,
    parameter int CNT_W      = 4,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    codon_counter_array_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bcnt_q, bcnt_d;
    logic [1:0]       phase_q, phase_d;
    logic [5:0]       win_q, win_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] cnt_q [NUM_CODONS];
    logic [CNT_W-1:0] cnt_d [NUM_CODONS];
    logic [5:0]       tbl_q [NUM_CODONS];
    logic [5:0]       tbl_d [NUM_CODONS];
`ifdef CODON_STOP_EN
    logic             stop_hit_q, stop_hit_d;
    logic             is_stop;
`endif

    logic             accept;
    logic             formed;
    logic [5:0]       win_nxt;
    logic [LEN_W-1:0] bcnt_inc;
    logic [1:0]       phase_inc;

    // phase tracks the base counter mod 3 so frame alignment needs no divider
    assign accept    = (state_q == S_SCAN) && bus.base_valid;
    assign win_nxt   = {win_q[3:0], bus.base};
    assign bcnt_inc  = bcnt_q + LEN_W'(1);
    assign phase_inc = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
    assign formed    = accept && (mode_q ? (bcnt_inc >= LEN_W'(3)) : (phase_inc == 2'd0));
`ifdef CODON_STOP_EN
    assign is_stop   = (win_nxt == 6'b110000) || (win_nxt == 6'b110010) || (win_nxt == 6'b111000);
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        win_d   = win_q;
        total_d = total_q;
        for (int i = 0; i < NUM_CODONS; i++) begin
            cnt_d[i] = cnt_q[i];
            tbl_d[i] = tbl_q[i];
        end
`ifdef CODON_STOP_EN
        stop_hit_d = stop_hit_q;
`endif
        case (state_q)
            S_IDLE: begin
                for (int i = 0; i < NUM_CODONS; i++) begin
                    if (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))) tbl_d[i] = bus.cfg_codon;
                end
                if (bus.start) begin
                    mode_d  = bus.mode;
                    len_d   = bus.gene_len;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                bcnt_d  = '0;
                phase_d = '0;
                win_d   = '0;
                total_d = '0;
                for (int i = 0; i < NUM_CODONS; i++) cnt_d[i] = '0;
`ifdef CODON_STOP_EN
                stop_hit_d = 1'b0;
`endif
                state_d = (len_q == '0) ? S_DONE : S_SCAN;
            end
            S_SCAN: begin
                if (accept) begin
                    win_d   = win_nxt;
                    bcnt_d  = bcnt_inc;
                    phase_d = phase_inc;
                    if (formed) begin
                        if (total_q != '1) total_d = total_q + CNT_W'(1);
                        for (int i = 0; i < NUM_CODONS; i++) begin
                            if ((win_nxt == tbl_q[i]) && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    if (bcnt_inc == len_q) state_d = S_DONE;
`ifdef CODON_STOP_EN
                    if (formed && is_stop) begin
                        stop_hit_d = 1'b1;
                        state_d    = S_DONE;
                    end
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            len_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= '0;
            win_q   <= '0;
            total_q <= '0;
            for (int i = 0; i < NUM_CODONS; i++) begin
                cnt_q[i] <= '0;
                tbl_q[i] <= '0;
            end
`ifdef CODON_STOP_EN
            stop_hit_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            win_q   <= win_d;
            total_q <= total_d;
            for (int i = 0; i < NUM_CODONS; i++) begin
                cnt_q[i] <= cnt_d[i];
                tbl_q[i] <= tbl_d[i];
            end
`ifdef CODON_STOP_EN
            stop_hit_q <= stop_hit_d;
`endif
        end
    end

    assign bus.base_ready   = (state_q == S_SCAN);
    assign bus.busy         = (state_q == S_CLEAR) || (state_q == S_SCAN);
    assign bus.done         = (state_q == S_DONE);
    assign bus.total_codons = total_q;
    assign bus.state_dbg    = state_q;
    assign bus.sel_count    = (int'(bus.sel) < NUM_CODONS) ? cnt_q[bus.sel] : '0;
`ifdef CODON_STOP_EN
    assign bus.stop_hit     = stop_hit_q;
`endif
endmodule

// File: tb/tb_codon_counter_array.sv
// Scoreboard bench for codon_counter_array: directed scans plus randomized scans
// checked against a base-list reference model (CODON_STOP_EN aware).
module tb_codon_counter_array;
    localparam int NUM_CODONS = 6;
    localparam int IDX_W      = 3;
    localparam int CNT_W      = 4;
    localparam int LEN_W      = 8;
    localparam int EXP_W      = 1 + CNT_W * (NUM_CODONS + 1);
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    codon_counter_array_if #(.IDX_W(IDX_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

    codon_counter_array #(
        .NUM_CODONS(NUM_CODONS), .IDX_W(IDX_W), .CNT_W(CNT_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;
    logic [EXP_W-1:0] exp_q[$];
    int               done_cyc_q[$];
    logic [5:0]       tbl_m [NUM_CODONS];
    logic [1:0]       stream_q[$];
    int               zero_req = 0;
    int               zero_ack = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic report_and_finish();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    endtask

    // Reference: walk the base list, form codons by position, count, saturate at the end.
    task automatic model_scan(input logic m, input int len, output logic [EXP_W-1:0] e, output int consumed);
        int         cnt [NUM_CODONS];
        int         tot;
        logic       stop;
        logic [5:0] cod;
        tot = 0;
        stop = 1'b0;
        consumed = len;
        for (int i = 0; i < NUM_CODONS; i++) cnt[i] = 0;
        for (int k = 1; k <= len; k++) begin
            if ((m == 1'b0 && (k % 3) == 0) || (m == 1'b1 && k >= 3)) begin
                cod = {stream_q[k-3], stream_q[k-2], stream_q[k-1]};
                tot++;
                for (int i = 0; i < NUM_CODONS; i++) if (tbl_m[i] == cod) cnt[i]++;
`ifdef CODON_STOP_EN
                if (cod == 6'b110000 || cod == 6'b110010 || cod == 6'b111000) begin
                    stop = 1'b1;
                    consumed = k;
                    break;
                end
`endif
            end
        end
        e = '0;
        for (int i = 0; i < NUM_CODONS; i++)
            e[CNT_W*i +: CNT_W] = CNT_W'((cnt[i] > CNT_MAX) ? CNT_MAX : cnt[i]);
        e[CNT_W*NUM_CODONS +: CNT_W] = CNT_W'((tot > CNT_MAX) ? CNT_MAX : tot);
        e[EXP_W-1] = stop;
    endtask

    task automatic push_codon(input logic [5:0] c);
        stream_q.push_back(c[5:4]);
        stream_q.push_back(c[3:2]);
        stream_q.push_back(c[1:0]);
    endtask

    task automatic cfg_write(input int idx, input logic [5:0] codon);
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = IDX_W'(idx);
        bus.cfg_codon = codon;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        if (idx < NUM_CODONS) tbl_m[idx] = codon;
    endtask

    task automatic run_scan(input logic m, input int len, input int gap_pct, input bit disturb);
        logic [EXP_W-1:0] e;
        int consumed, idx, budget, s;
        logic acc;
        model_scan(m, len, e, consumed);
        exp_q.push_back(e);
        bus.mode     = m;
        bus.gene_len = len[LEN_W-1:0];
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        s = cyc;
        check("busy_in_clear", {31'd0, bus.busy}, 32'd1);
        if (len == 0) begin
            done_cyc_q.push_back(s + 1);
            if (disturb) begin
                bus.start     = 1'b1;
                bus.mode      = ~m;
                bus.gene_len  = 5;
                bus.cfg_we    = 1'b1;
                bus.cfg_idx   = '0;
                bus.cfg_codon = ~tbl_m[0];
            end
            @(posedge clk); #1;
            bus.start  = 1'b0;
            bus.cfg_we = 1'b0;
            check("ready_in_done", {31'd0, bus.base_ready}, 32'd0);
        end else begin
            idx = 0;
            budget = 0;
            while (idx < consumed && budget < 20 * len + 50) begin
                bus.base_valid = ($urandom_range(99) >= gap_pct);
                bus.base = bus.base_valid ? stream_q[idx] : 2'($urandom_range(3));
                acc = bus.base_valid && bus.base_ready;
                @(posedge clk); #1;
                budget++;
                if (acc) idx++;
            end
            bus.base_valid = 1'b0;
            if (idx < consumed) begin
                n_vec++;
                n_fail++;
                $display("FAIL base_accept_timeout: got %0d bases expected %0d", idx, consumed);
                report_and_finish();
            end
            done_cyc_q.push_back(cyc);
            check("ready_low_after_last", {31'd0, bus.base_ready}, 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic reset_midscan();
        int idx;
        logic acc;
        stream_q.delete();
        push_codon(6'b001110); push_codon(6'b001110); push_codon(6'b010101);
        bus.mode = 1'b0; bus.gene_len = 9; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        idx = 0;
        for (int b = 0; b < 20 && idx < 4; b++) begin
            bus.base_valid = 1'b1;
            bus.base = stream_q[idx];
            acc = bus.base_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        bus.base_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_ready", {31'd0, bus.base_ready}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        zero_req++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NUM_CODONS; i++) tbl_m[i] = '0;
    endtask

    // Monitor: pops expectations on each done pulse and on reset zero-check requests.
    initial begin
        logic [EXP_W-1:0] e;
        int dc;
        forever begin
            @(negedge clk);
            if (zero_req != zero_ack) begin
                for (int s = 0; s < (1 << IDX_W); s++) begin
                    bus.sel = IDX_W'(s);
                    #1;
                    check($sformatf("zero_sel_count[%0d]", s), 32'(bus.sel_count), 32'd0);
                end
                check("zero_total", 32'(bus.total_codons), 32'd0);
`ifdef CODON_STOP_EN
                check("zero_stop_hit", {31'd0, bus.stop_hit}, 32'd0);
`endif
                zero_ack++;
            end else if (bus.done) begin
                if (exp_q.size() == 0 || done_cyc_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
                end else begin
                    e  = exp_q.pop_front();
                    dc = done_cyc_q.pop_front();
                    check("done_cycle", cyc, dc);
                    for (int s = 0; s < (1 << IDX_W); s++) begin
                        bus.sel = IDX_W'(s);
                        #1;
                        check($sformatf("sel_count[%0d]", s), 32'(bus.sel_count),
                              (s < NUM_CODONS) ? 32'(e[CNT_W*s +: CNT_W]) : 32'd0);
                    end
                    check("total_codons", 32'(bus.total_codons), 32'(e[CNT_W*NUM_CODONS +: CNT_W]));
`ifdef CODON_STOP_EN
                    check("stop_hit", {31'd0, bus.stop_hit}, {31'd0, e[EXP_W-1]});
`endif
                end
            end
        end
    end

    initial begin
        #2000000;
        n_vec++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        report_and_finish();
    end

    // Driver
    initial begin
        int len, nw, r;
        bus.start = 0; bus.mode = 0; bus.gene_len = '0; bus.base_valid = 0; bus.base = '0;
        bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_codon = '0; bus.sel = '0;
        for (int i = 0; i < NUM_CODONS; i++) tbl_m[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_ready", {31'd0, bus.base_ready}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        zero_req++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Frame-aligned and sliding-window over ATGATGCCC
        cfg_write(0, 6'b001110);
        cfg_write(1, 6'b010101);
        stream_q.delete();
        push_codon(6'b001110); push_codon(6'b001110); push_codon(6'b010101);
        run_scan(1'b0, 9, 0, 1'b0);
        run_scan(1'b1, 9, 0, 1'b0);

        // Zero-length scan with ignored start/cfg during busy, then table still intact
        run_scan(1'b0, 0, 0, 1'b1);
        run_scan(1'b0, 9, 0, 1'b0);

        // Saturation across upstream stalls
        stream_q.delete();
        for (int i = 0; i < 20; i++) push_codon(6'b001110);
        run_scan(1'b0, 60, 40, 1'b0);

        // Reset mid-scan, then all-AAA scan shows the cleared table
        reset_midscan();
        @(posedge clk); #1;
        stream_q.delete();
        for (int i = 0; i < 3; i++) push_codon(6'b000000);
        run_scan(1'b0, 9, 0, 1'b0);

`ifdef CODON_STOP_EN
        cfg_write(0, 6'b001110);
        stream_q.delete();
        push_codon(6'b001110); push_codon(6'b110000); push_codon(6'b001110);
        run_scan(1'b0, 9, 0, 1'b0);
`endif

        // Randomized scans
        for (int t = 0; t < 40; t++) begin
            nw = $urandom_range(4);
            for (int w = 0; w < nw; w++) begin
                if ($urandom_range(3) == 0) cfg_write($urandom_range(7), tbl_m[$urandom_range(NUM_CODONS-1)]);
                else cfg_write($urandom_range(7), 6'($urandom_range(63)));
            end
            r = $urandom_range(9);
            if (r < 2)       len = $urandom_range(3);
            else if (r == 9) len = $urandom_range(255, 120);
            else             len = $urandom_range(60, 3);
            stream_q.delete();
            while (stream_q.size() < len) begin
                if ($urandom_range(1) == 0) push_codon(tbl_m[$urandom_range(NUM_CODONS-1)]);
                else stream_q.push_back(2'($urandom_range(3)));
            end
            while (stream_q.size() > len) void'(stream_q.pop_back());
            run_scan(1'($urandom_range(1)), len, $urandom_range(60), 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("pending_expectations", exp_q.size(), 32'd0);
        report_and_finish();
    end
endmodule

// File: doc/codon_counter_array.md
Name: codon_counter_array

Overview:
- Parametrised successor of the fixed six-codon gene scanner.
- Consumes a nucleotide stream over a valid/ready handshake and groups bases into codons, in either frame-aligned or sliding-window mode.
- Counts matches against a runtime-loadable table of NUM_CODONS target codons.
- Sits between the gene source (memory reader or stream) and the switch/LED readout logic.

Parameters:
NUM_CODONS, 6, number of target codon table entries / counters
IDX_W, 3, table index width; must satisfy 2**IDX_W >= NUM_CODONS
CNT_W, 4, width of each match counter and of the total-codon counter (saturating)
LEN_W, 8, width of gene length in bases

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin a scan (sampled in IDLE only)
mode  in  1  0 = frame-aligned codons, 1 = sliding window; sampled on accepted start
gene_len  in  LEN_W  number of bases to consume; sampled on accepted start
base_valid  in  1  base stream valid
base  in  2  nucleotide: A=00, C=01, G=10, T=11
base_ready  out  1  block accepts a base
cfg_we  in  1  table write strobe
cfg_idx  in  IDX_W  table entry to write
cfg_codon  in  6  codon value {b0,b1,b2}, first base in MSBs
sel  in  IDX_W  counter select for readout
sel_count  out  CNT_W  count of entry sel; 0 if sel >= NUM_CODONS
total_codons  out  CNT_W  codons formed in the current/last scan (saturating)
busy  out  1  high in CLEAR and SCAN
done  out  1  one-cycle pulse at scan completion

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - All counters, total_codons, base counter and window = 0.
  - All table entries = 0 (AAA).
  - base_ready = 0, busy = 0, done = 0.
- States: IDLE -> CLEAR -> SCAN -> DONE -> IDLE.
- IDLE:
  - cfg_we writes cfg_codon to entry cfg_idx on the clock edge; cfg_idx >= NUM_CODONS is ignored.
  - start = 1 latches mode and gene_len, then -> CLEAR.
- CLEAR (1 cycle):
  - Zero all counters, total_codons, base counter and window.
  - gene_len == 0 -> DONE; otherwise -> SCAN.
- SCAN:
  - base_ready = 1.
  - A base is accepted on a cycle with base_valid && base_ready. Window shifts left by 2 bits, new base enters the LSBs, base counter increments.
  - Codon formed on an accepted base when:
    - mode 0: base counter (after increment) mod 3 == 0;
    - mode 1: base counter (after increment) >= 3.
  - On each formed codon:
    - The codon is compared against all NUM_CODONS entries in parallel.
    - Every matching entry's counter increments; duplicate table entries all increment.
    - total_codons increments on every formed codon, match or not.
    - All counters saturate at 2**CNT_W-1.
  - When the accepted base makes base counter == gene_len -> DONE, in the same edge as the final count update.
  - Trailing bases that do not complete a frame (mode 0) are consumed but not counted.
  - gene_len 1 or 2: no codons formed.
- DONE (1 cycle): done = 1, base_ready = 0 -> IDLE.
- Ignored inputs:
  - start while not in IDLE.
  - cfg_we while not in IDLE.
- Readout and results:
  - sel_count is combinational from sel and the registered counters.
  - An update caused by a base accepted at edge N is visible after edge N.
  - Counters and total_codons hold after DONE until the next start enters CLEAR.
- Reset mid-scan: immediate return to IDLE with all state cleared, including the table.
- Upstream stalls (base_valid low): no state change; SCAN waits indefinitely.

Optional Feature:
- Macro: CODON_STOP_EN.
- Defined:
  - In SCAN, a formed codon equal to TAA (110000), TAG (110010) or TGA (111000) is counted normally in table counters and total_codons.
  - The FSM then goes directly to DONE on that edge, even if base counter < gene_len.
  - Remaining upstream bases are not consumed.
  - Extra output port stop_hit (1 bit) is set on that edge, held until the next CLEAR, and cleared by reset.
- Not defined: stop codons are ordinary codons; there is no stop_hit port.

Test Plan:
1. Table entry0 = ATG (001110), entry1 = CCC (010101); mode 0, gene_len 9, stream ATGATGCCC with valid held high -> entry0 = 2, entry1 = 1, total_codons = 3, done pulses the cycle after the 9th base.
2. Same table and stream, mode 1 -> codons ATG, TGA, GAT, ATG, TGC, GCC, CCC; entry0 = 2, entry1 = 1, total_codons = 7.
3. CNT_W = 4, mode 0, entry0 = ATG, 20 x ATG (gene_len 60) with random base_valid gaps -> entry0 = 15, total_codons = 15 (saturated), no base lost across stalls.
4. gene_len = 0, start -> busy for 1 cycle (CLEAR), done high the next cycle, all counts 0; cfg_we and start pulses during busy have no effect.
5. Assert rst after 4 bases of a 9-base scan -> outputs 0 immediately, all table entries read back as 0 after re-scan of AAA, FSM accepts new start.
6. CODON_STOP_EN defined, entry0 = ATG, mode 0, gene_len 9, stream ATGTAAATG -> DONE after 6th base, entry0 = 1, total_codons = 2, stop_hit = 1, base_ready = 0 with 3 bases unconsumed.
